// File: rtl/halftone_pkg.sv
// halftone_pkg: shared types and constants for the Floyd-Steinberg halftoner.
//   err_t           8-bit signed diffused-error type
//   W_RIGHT/W_BL/W_BELOW/W_BR  diffusion weights in sixteenths (7/3/5/1)
//   ERR_SHIFT       divide-by-16 shift amount
//   WHITE_LEVEL     quantised value of a set output pixel
//   THRESH_DEFAULT  default threshold
//   weigh_err()     (w*e) >>> 4 with floor rounding toward minus infinity
package halftone_pkg;

  typedef logic signed [7:0] err_t;

  localparam logic [3:0]  W_RIGHT        = 4'd7;
  localparam logic [3:0]  W_BL           = 4'd3;
  localparam logic [3:0]  W_BELOW        = 4'd5;
  localparam logic [3:0]  W_BR           = 4'd1;
  localparam int unsigned ERR_SHIFT      = 4;
  localparam logic [7:0]  WHITE_LEVEL    = 8'd255;
  localparam int          THRESH_DEFAULT = 128;

  // |w*e| <= 7*127 = 889, so a 12-bit signed product never overflows and
  // the shifted result always fits back into err_t.
  function automatic err_t weigh_err(input err_t e, input logic [3:0] w);
    logic signed [11:0] prod;
    logic signed [11:0] shifted;
    prod    = $signed({{4{e[7]}}, e}) * $signed({8'b0000_0000, w});
    shifted = prod >>> ERR_SHIFT;
    return shifted[7:0];
  endfunction

endpackage

// File: rtl/halftone_errbuf.sv
// halftone_errbuf: one row of pending error for the next image row.
//   clk          clock
//   rd_addr_i    combinational read column (current x)
//   rd_data_o    buffered error for rd_addr_i
//   wr0_en_i/wr0_addr_i/wr0_data_i  trailing write (column x-1)
//   wr1_en_i/wr1_addr_i/wr1_data_i  row-end write (column x at the last column)
// Contents are not reset: row 0 of every frame masks all reads.
module halftone_errbuf
  import halftone_pkg::*;
#(
  parameter int IMG_W = 16,
  parameter int AW    = 4
) (
  input  logic          clk,
  input  logic [AW-1:0] rd_addr_i,
  output logic [7:0]    rd_data_o,
  input  logic          wr0_en_i,
  input  logic [AW-1:0] wr0_addr_i,
  input  logic [7:0]    wr0_data_i,
  input  logic          wr1_en_i,
  input  logic [AW-1:0] wr1_addr_i,
  input  logic [7:0]    wr1_data_i
);

  err_t mem_q [IMG_W];

  assign rd_data_o = mem_q[rd_addr_i];

  // Storage update; the two ports always address different columns (x-1 vs x).
  always_ff @(posedge clk) begin
    for (int i = 0; i < IMG_W; i++) begin
      if (wr1_en_i && (wr1_addr_i == AW'(i))) begin
        mem_q[i] <= $signed(wr1_data_i);
      end else if (wr0_en_i && (wr0_addr_i == AW'(i))) begin
        mem_q[i] <= $signed(wr0_data_i);
      end
    end
  end

endmodule

// File: rtl/halftone_fs.sv
// halftone_fs: streaming Floyd-Steinberg halftoner, one gray pixel in,
// one halftone bit out per handshake, 1-cycle registered latency.
//   clk, rst               clock, synchronous active-high reset
//   in_gray/in_sof/in_valid/in_ready   input pixel stream (raster order)
//   out_pix/out_eol/out_eof/out_valid/out_ready   output bit stream
// Build option: define HALFTONE_DIFFUSE_EN for full error diffusion; when it
// is undefined the output is a plain threshold of in_gray and no error
// storage is built.
module halftone_fs
  import halftone_pkg::*;
#(
  parameter int IMG_W  = 16,
  parameter int IMG_H  = 16,
  parameter int THRESH = THRESH_DEFAULT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] in_gray,
  input  logic       in_sof,
  input  logic       in_valid,
  output logic       in_ready,
  output logic       out_pix,
  output logic       out_eol,
  output logic       out_eof,
  output logic       out_valid,
  input  logic       out_ready
);

  localparam int            XW       = $clog2(IMG_W);
  localparam int            YW       = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam logic [XW-1:0] X_LAST   = XW'(IMG_W - 1);
  localparam logic [YW-1:0] Y_LAST   = YW'(IMG_H - 1);
  localparam logic [XW-1:0] X_ZERO   = {XW{1'b0}};
  localparam logic [YW-1:0] Y_ZERO   = {YW{1'b0}};
  localparam logic [8:0]    THRESH_9 = 9'(THRESH);

  logic          accept_s;
  logic [XW-1:0] x_q, x_d, x_eff_s;
  logic [YW-1:0] y_q, y_d, y_eff_s;
  logic          row_last_s;
  logic          frame_last_s;
  logic          pix_s;
  logic          out_valid_q, out_valid_d;
  logic          out_pix_q, out_pix_d;
  logic          out_eol_q, out_eol_d;
  logic          out_eof_q, out_eof_d;

  assign in_ready  = !out_valid_q || out_ready;
  assign accept_s  = in_valid && in_ready;

  // A start-of-frame pixel is always column 0 of row 0, aborting any frame.
  assign x_eff_s      = in_sof ? X_ZERO : x_q;
  assign y_eff_s      = in_sof ? Y_ZERO : y_q;
  assign row_last_s   = (x_eff_s == X_LAST);
  assign frame_last_s = row_last_s && (y_eff_s == Y_LAST);

  assign out_valid = out_valid_q;
  assign out_pix   = out_pix_q;
  assign out_eol   = out_eol_q;
  assign out_eof   = out_eof_q;

`ifdef HALFTONE_DIFFUSE_EN
  err_t          e_right_q, e_right_d;
  err_t          pend_cur_q, pend_cur_d;
  err_t          pend_prev_q, pend_prev_d;
  logic [7:0]    buf_rd_s;
  err_t          e_below_s;
  err_t          e_right_eff_s;
  logic signed [9:0] acc_s;
  logic [7:0]    clamped_s;
  logic signed [8:0] err_wide_s;
  err_t          err_s;
  err_t          c_right_s, c_bl_s, c_below_s, c_br_s;
  err_t          pend_cur_eff_s;
  err_t          pend_prev_new_s;
  logic          wr0_en_s, wr1_en_s;
  logic [XW-1:0] wr0_addr_s;
  logic [7:0]    wr0_data_s, wr1_data_s;

  halftone_errbuf #(
    .IMG_W (IMG_W),
    .AW    (XW)
  ) u_errbuf (
    .clk        (clk),
    .rd_addr_i  (x_eff_s),
    .rd_data_o  (buf_rd_s),
    .wr0_en_i   (wr0_en_s),
    .wr0_addr_i (wr0_addr_s),
    .wr0_data_i (wr0_data_s),
    .wr1_en_i   (wr1_en_s),
    .wr1_addr_i (x_eff_s),
    .wr1_data_i (wr1_data_s)
  );

  // Row 0 has no row above; column 0 has no pixel to its left.
  assign e_below_s     = (y_eff_s == Y_ZERO) ? 8'sd0 : $signed(buf_rd_s);
  assign e_right_eff_s = (x_eff_s == X_ZERO) ? 8'sd0 : e_right_q;

  assign acc_s = $signed({2'b00, in_gray})
               + $signed({{2{e_right_eff_s[7]}}, e_right_eff_s})
               + $signed({{2{e_below_s[7]}}, e_below_s});

  // Saturate the corrected intensity to the 8-bit pixel range.
  always_comb begin
    clamped_s = 8'd0;
    if (acc_s < 10'sd0) begin
      clamped_s = 8'd0;
    end else if (acc_s > 10'sd255) begin
      clamped_s = 8'd255;
    end else begin
      clamped_s = acc_s[7:0];
    end
  end

  assign pix_s      = ({1'b0, clamped_s} >= THRESH_9);
  assign err_wide_s = $signed({1'b0, clamped_s})
                    - (pix_s ? $signed({1'b0, WHITE_LEVEL}) : 9'sd0);
  assign err_s      = err_wide_s[7:0];

  assign c_right_s = weigh_err(err_s, W_RIGHT);
  assign c_bl_s    = weigh_err(err_s, W_BL);
  assign c_below_s = weigh_err(err_s, W_BELOW);
  assign c_br_s    = weigh_err(err_s, W_BR);

  // At column 0 any leftover pending error belongs to an aborted row.
  assign pend_cur_eff_s  = (x_eff_s == X_ZERO) ? 8'sd0 : pend_cur_q;
  assign pend_prev_new_s = pend_cur_eff_s + c_below_s;

  // Column x-1 of the next row is complete once this pixel adds its 3/16.
  assign wr0_en_s   = accept_s && (x_eff_s != X_ZERO);
  assign wr0_addr_s = x_eff_s - 1'b1;
  assign wr0_data_s = pend_prev_q + c_bl_s;
  assign wr1_en_s   = accept_s && row_last_s;
  assign wr1_data_s = pend_prev_new_s;

  // Next-state for the right-neighbour error and the two pending columns.
  always_comb begin
    e_right_d   = e_right_q;
    pend_cur_d  = pend_cur_q;
    pend_prev_d = pend_prev_q;
    if (accept_s) begin
      if (row_last_s) begin
        e_right_d   = 8'sd0;
        pend_cur_d  = 8'sd0;
        pend_prev_d = 8'sd0;
      end else begin
        e_right_d   = c_right_s;
        pend_cur_d  = c_br_s;
        pend_prev_d = pend_prev_new_s;
      end
    end else begin
      e_right_d   = e_right_q;
      pend_cur_d  = pend_cur_q;
      pend_prev_d = pend_prev_q;
    end
  end

  // Error state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      e_right_q   <= 8'sd0;
      pend_cur_q  <= 8'sd0;
      pend_prev_q <= 8'sd0;
    end else begin
      e_right_q   <= e_right_d;
      pend_cur_q  <= pend_cur_d;
      pend_prev_q <= pend_prev_d;
    end
  end
`else
  assign pix_s = ({1'b0, in_gray} >= THRESH_9);
`endif

  // Raster position: advance on accept, wrap at row and frame ends.
  always_comb begin
    x_d = x_q;
    y_d = y_q;
    if (accept_s) begin
      if (row_last_s) begin
        x_d = X_ZERO;
        if (frame_last_s) begin
          y_d = Y_ZERO;
        end else begin
          y_d = y_eff_s + 1'b1;
        end
      end else begin
        x_d = x_eff_s + 1'b1;
        y_d = y_eff_s;
      end
    end else begin
      x_d = x_q;
      y_d = y_q;
    end
  end

  // Output stage: load on accept, clear valid on drain, otherwise hold.
  always_comb begin
    out_valid_d = out_valid_q;
    out_pix_d   = out_pix_q;
    out_eol_d   = out_eol_q;
    out_eof_d   = out_eof_q;
    if (accept_s) begin
      out_valid_d = 1'b1;
      out_pix_d   = pix_s;
      out_eol_d   = row_last_s;
      out_eof_d   = frame_last_s;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end else begin
      out_valid_d = out_valid_q;
    end
  end

  // Position and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      x_q         <= X_ZERO;
      y_q         <= Y_ZERO;
      out_valid_q <= 1'b0;
      out_pix_q   <= 1'b0;
      out_eol_q   <= 1'b0;
      out_eof_q   <= 1'b0;
    end else begin
      x_q         <= x_d;
      y_q         <= y_d;
      out_valid_q <= out_valid_d;
      out_pix_q   <= out_pix_d;
      out_eol_q   <= out_eol_d;
      out_eof_q   <= out_eof_d;
    end
  end

endmodule

// File: tb/tb_halftone_fs.sv
// tb_halftone_fs: directed self-checking bench for halftone_fs on a 4x2 image.
// Expected bit patterns were worked out by hand for both build options.
module tb_halftone_fs;

  localparam int W = 4;
  localparam int H = 2;

  logic       clk;
  logic       rst;
  logic [7:0] in_gray;
  logic       in_sof;
  logic       in_valid;
  logic       in_ready;
  logic       out_pix;
  logic       out_eol;
  logic       out_eof;
  logic       out_valid;
  logic       out_ready;

  int n_tests = 0;
  int n_fail  = 0;

  // Pixel i of a frame lives in bits [8*i +: 8]; expected bit i is pixel i.
  localparam logic [63:0] FRAME_F   = {8'd10, 8'd90, 8'd200, 8'd60, 8'd220, 8'd30, 8'd150, 8'd100};
  localparam logic [63:0] FRAME_0   = {8{8'd0}};
  localparam logic [63:0] FRAME_255 = {8{8'd255}};
  localparam logic [63:0] FRAME_100 = {8{8'd100}};
  localparam logic [63:0] FRAME_128 = {8{8'd128}};
  localparam logic [63:0] FRAME_JNK = {8{8'd200}};
  localparam logic [7:0]  EXP_F     = 8'b0010_1010;
`ifdef HALFTONE_DIFFUSE_EN
  localparam logic [7:0]  EXP_100   = 8'b1010_0010;
  localparam logic [7:0]  EXP_128   = 8'b1010_0101;
`else
  localparam logic [7:0]  EXP_100   = 8'b0000_0000;
  localparam logic [7:0]  EXP_128   = 8'b1111_1111;
`endif

  halftone_fs #(
    .IMG_W  (W),
    .IMG_H  (H),
    .THRESH (128)
  ) u_dut (
    .clk       (clk),
    .rst       (rst),
    .in_gray   (in_gray),
    .in_sof    (in_sof),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_pix   (out_pix),
    .out_eol   (out_eol),
    .out_eof   (out_eof),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Present one pixel, let it be accepted, sample outputs 1 time unit later.
  task automatic push(input logic [7:0] g, input logic sof, output logic [3:0] obs);
    in_gray  = g;
    in_sof   = sof;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    obs    = {out_valid, out_pix, out_eol, out_eof};
    in_sof = 1'b0;
  endtask

  task automatic test_reset();
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_sof    = 1'b0;
    in_gray   = 8'd0;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    n_tests++;
    if ({out_valid, out_pix, out_eol, out_eof, in_ready} !== 5'b00001) begin
      n_fail++;
      $display("FAIL reset: got v/pix/eol/eof/rdy=%b expected 00001",
               {out_valid, out_pix, out_eol, out_eof, in_ready});
    end
  endtask

  task automatic test_frames();
    logic [63:0] px  [4];
    logic [7:0]  exp [4];
    logic [3:0]  obs;
    logic [3:0]  want;
    px[0] = FRAME_0;   exp[0] = 8'h00;
    px[1] = FRAME_255; exp[1] = 8'hFF;
    px[2] = FRAME_100; exp[2] = EXP_100;
    px[3] = FRAME_128; exp[3] = EXP_128;
    for (int f = 0; f < 4; f++) begin
      for (int i = 0; i < 8; i++) begin
        want = {1'b1, exp[f][i], (i == 3) || (i == 7), i == 7};
        push(px[f][8*i +: 8], i == 0, obs);
        n_tests++;
        if (obs !== want) begin
          n_fail++;
          $display("FAIL frame%0d pix%0d: got v/pix/eol/eof=%b expected %b", f, i, obs, want);
        end
      end
      in_valid = 1'b0;
      @(posedge clk);
      #1;
      n_tests++;
      if (out_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL frame%0d drain: got out_valid=%b expected 0", f, out_valid);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [3:0] obs;
    logic [3:0] want;
    for (int i = 0; i < 3; i++) begin
      want = {1'b1, EXP_F[i], 1'b0, 1'b0};
      push(FRAME_F[8*i +: 8], i == 0, obs);
      n_tests++;
      if (obs !== want) begin
        n_fail++;
        $display("FAIL bp pix%0d: got %b expected %b", i, obs, want);
      end
    end
    out_ready = 1'b0;
    in_gray   = FRAME_F[31:24];
    in_valid  = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk);
      #1;
      n_tests++;
      if ({out_valid, out_pix, out_eol, out_eof, in_ready} !== {1'b1, EXP_F[2], 3'b000}) begin
        n_fail++;
        $display("FAIL bp stall%0d: got v/pix/eol/eof/rdy=%b expected %b", k,
                 {out_valid, out_pix, out_eol, out_eof, in_ready}, {1'b1, EXP_F[2], 3'b000});
      end
    end
    out_ready = 1'b1;
    for (int i = 3; i < 8; i++) begin
      want = {1'b1, EXP_F[i], (i == 3) || (i == 7), i == 7};
      push(FRAME_F[8*i +: 8], 1'b0, obs);
      n_tests++;
      if (obs !== want) begin
        n_fail++;
        $display("FAIL bp pix%0d: got %b expected %b", i, obs, want);
      end
    end
    in_valid = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_rst_abort();
    logic [3:0] obs;
    logic [3:0] want;
    for (int i = 0; i < 5; i++) push(FRAME_JNK[8*i +: 8], i == 0, obs);
    in_valid = 1'b0;
    rst      = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    n_tests++;
    if ({out_valid, in_ready} !== 2'b01) begin
      n_fail++;
      $display("FAIL rst_abort reset: got v/rdy=%b expected 01", {out_valid, in_ready});
    end
    // No in_sof: the reset alone must restart at (0,0).
    for (int i = 0; i < 8; i++) begin
      want = {1'b1, EXP_F[i], (i == 3) || (i == 7), i == 7};
      push(FRAME_F[8*i +: 8], 1'b0, obs);
      n_tests++;
      if (obs !== want) begin
        n_fail++;
        $display("FAIL rst_abort pix%0d: got %b expected %b", i, obs, want);
      end
    end
    in_valid = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_sof_abort();
    logic [3:0] obs;
    logic [3:0] want;
    for (int i = 0; i < 5; i++) push(FRAME_JNK[8*i +: 8], i == 0, obs);
    for (int i = 0; i < 8; i++) begin
      want = {1'b1, EXP_F[i], (i == 3) || (i == 7), i == 7};
      push(FRAME_F[8*i +: 8], i == 0, obs);
      n_tests++;
      if (obs !== want) begin
        n_fail++;
        $display("FAIL sof_abort pix%0d: got %b expected %b", i, obs, want);
      end
    end
    in_valid = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_back_to_back();
    logic [127:0] px;
    logic [15:0]  exp;
    logic [3:0]   obs;
    logic [3:0]   want;
    px  = {FRAME_100, FRAME_F};
    exp = {EXP_100, EXP_F};
    // Second frame carries no in_sof: the counters must wrap on their own.
    for (int i = 0; i < 16; i++) begin
      want = {1'b1, exp[i], (i % 4) == 3, (i % 8) == 7};
      push(px[8*i +: 8], i == 0, obs);
      n_tests++;
      if (obs !== want) begin
        n_fail++;
        $display("FAIL b2b pix%0d: got %b expected %b", i, obs, want);
      end
    end
    in_valid = 1'b0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    test_reset();
    test_frames();
    test_backpressure();
    test_rst_abort();
    test_sof_abort();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/halftone_fs.md
# halftone_fs

Streaming Floyd–Steinberg halftoner, directly downstream of the grayscale converter. Accepts one 8-bit gray pixel per handshake in raster order, adds diffused quantisation error from neighbours, thresholds to 1 bit, and emits one halftone bit per pixel with row/frame markers. It holds one row of pending error for the next image row.

## Interface
- `IMG_W`, default 16: pixels per row (≥2).
- `IMG_H`, default 16: rows per frame (≥1).
- `THRESH`, default 128: output is 1 when the clamped sum is ≥ THRESH.
- `clk`  in  1  single clock; all logic acts on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `in_gray`  in  8  gray pixel from the grayscale stage.
- `in_sof`  in  1  marks the first pixel of a frame; qualified by `in_valid`.
- `in_valid`  in  1  input pixel valid.
- `in_ready`  out  1  stage can accept a pixel.
- `out_pix`  out  1  halftone bit.
- `out_eol`  out  1  `out_pix` is the last pixel of a row.
- `out_eof`  out  1  `out_pix` is the last pixel of the frame.
- `out_valid`  out  1  output valid.
- `out_ready`  in  1  downstream accepts output.

## Operation
- Accept happens when `in_valid && in_ready`. `in_ready = !out_valid || out_ready` (combinational).
- Position counters: x in 0..IMG_W-1 and y in 0..IMG_H-1. Both advance on each accept. An accept with `in_sof` forces the pixel to (0,0). After the last pixel the counters wrap to (0,0).
- Sum: `acc = in_gray + e_right + e_below`, 10-bit signed.
  - `e_below` = buf[x], forced to 0 when y==0.
  - `e_right` is forced to 0 when x==0.
- Clamp `acc` to 0..255. `out_pix = (clamped ≥ THRESH)`. Error `e = clamped − (out_pix ? 255 : 0)`, range −127..127.
- Weights are in sixteenths: right 7, below-left 3, below 5, below-right 1.
  - Each contribution is `(w*e) >>> 4`, an arithmetic shift, so results floor toward −∞.
  - Contributions that fall outside the image are dropped: below-left at x==0, right and below-right at x==IMG_W-1.
- Line buffer: IMG_W entries, 8-bit signed. Read/write order:
  - Read buf[x] before writing for row y+1.
  - Two pending registers: `pend_cur` holds column x+1 of the next row, `pend_prev` holds column x.
  - At x: write buf[x-1] ← old `pend_prev` + 3e/16 (skipped when x==0); `pend_prev` ← `pend_cur` + 5e/16; `pend_cur` ← e/16.
  - At x==IMG_W-1: also write buf[x] ← the new `pend_prev`, then clear both pending registers.
- Writes from row IMG_H-1 are harmless, because row 0 of the next frame masks all buffer reads.

## Timing
- Reset values: `out_valid`=0, `out_pix`=0, `out_eol`=0, `out_eof`=0, x=y=0, `e_right`=0, pending registers=0. `in_ready`=1 after reset. Buffer contents are don't-care because row 0 masks them.
- Latency is 1 cycle: a pixel accepted at edge k is presented at edge k with `out_valid`=1. A full-rate stream gives 1 pixel/cycle.
- Output hold: while `out_valid && !out_ready`, all outputs stay stable and no input is accepted.
- Accept and output drain in the same cycle is legal: the new result replaces the old one.
- `rst` mid-frame discards the output and all error state. The next pixel is treated as (0,0) whether or not `in_sof` is set.
- `in_sof` mid-frame aborts the current frame. Pending errors are dropped and rows restart at y=0 masking.

## Configuration
- `HALFTONE_DIFFUSE_EN` defined: full error diffusion as described above.
- `HALFTONE_DIFFUSE_EN` undefined: the line buffer, pending registers and `e_right` are not built. `out_pix = (in_gray ≥ THRESH)`. Handshake, counters, markers and latency are unchanged.

## Structure
- `halftone_pkg` holds: the weight constants (7, 3, 5, 1), the shift amount 4, the white level 255, the default `THRESH`, and the `err_t` type (8-bit signed).
- Sub-module `halftone_errbuf`: IMG_W×8 register array with one combinational read port (x) and two write ports (x-1, and x at row end). It has no reset.

## Test plan
- All-0 frame (IMG_W=4, IMG_H=2) → 8 outputs of 0. `out_eol` on pixels 3 and 7, `out_eof` on pixel 7.
- All-255 frame → all outputs 1. `e`=0 throughout.
- Row 0 = 100,100,100,100 → outputs 0,1,0,0. After the row, buf[0]=10.
- Same row with `HALFTONE_DIFFUSE_EN` undefined → 0,0,0,0. A pixel of 128 → 1.
- Backpressure: `out_ready` held low for 5 cycles mid-row → `out_valid`/`out_pix` held, `in_ready`=0, and the final bit sequence is identical to the unstalled run.
- `rst` pulse at pixel 5, or `in_sof` at pixel 5, then a fresh frame → output bit-identical to the same frame run from a clean reset.
